// File: rtl/popcount_pkg.sv
// popcount_pkg: shared definitions for the popcount scheduler.
//   state_t   - scheduler FSM states (IDLE, CALC, RESP)
//   cnt_width - bits needed to hold a popcount of 0..dw inclusive
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // A dw-bit word can hold dw ones, so one bit beyond $clog2(dw) is needed.
  function automatic int cnt_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/popcount_unit.sv
// popcount_unit: combinational count of set bits in a word.
//   din  - input word, DATA_WIDTH bits
//   dout - number of 1 bits in din, 0..DATA_WIDTH
module popcount_unit
  import popcount_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [cnt_width(DATA_WIDTH)-1:0] dout
);

  localparam int CW = cnt_width(DATA_WIDTH);

  always_comb begin
    dout = '0;
    for (int i = 0; i < DATA_WIDTH; i++) dout = dout + CW'(din[i]);
  end

endmodule

// File: rtl/popcount_sched.sv
// popcount_sched: round-robin arbiter feeding a single popcount unit.
//   clk, resetn - rising-edge clock, synchronous active-low reset
//   req_valid   - per-requester request valid (NUM_REQ bits)
//   req_data    - requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   - combinational one-hot grant strobe, only in IDLE
//   rsp_valid   - result valid, held until rsp_ready
//   rsp_ready   - consumer accepts the result
//   rsp_id      - index of the served requester
//   rsp_count   - popcount of the served word
// One request is in flight at a time: IDLE grants, CALC registers the
// count, RESP holds the result until the consumer takes it.
module popcount_sched
  import popcount_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [cnt_width(DATA_WIDTH)-1:0] rsp_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(DATA_WIDTH);

  state_t                            state;
  logic [IW-1:0]                     last_grant;
  logic [IW-1:0]                     lat_id;
  logic [DATA_WIDTH-1:0]             lat_data;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_words;
  logic [CW-1:0]                     pc_out;

  logic          found;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] cand;
  int            idx;

  assign req_words = req_data;

  // Round-robin search starting just after the last grant. Gated by resetn
  // so no strobe escapes while reset is held.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    idx      = 0;
    if (resetn && state == IDLE) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = IW'(idx);
        if (!found && req_valid[cand]) begin
          found    = 1'b1;
          grant_id = cand;
        end
      end
    end
  end

  assign req_ready = found ? (NUM_REQ'(1) << grant_id) : '0;

  popcount_unit #(.DATA_WIDTH(DATA_WIDTH)) u_pc (
    .din  (lat_data),
    .dout (pc_out)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      lat_id     <= '0;
      lat_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            lat_data   <= req_words[grant_id];
            lat_id     <= grant_id;
            last_grant <= grant_id;
            state      <= CALC;
          end
        end
        CALC: begin
          rsp_count <= pc_out;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_sched.sv
// tb_popcount_sched: directed checks of grant order, latency, hold,
// reset abort and data capture for popcount_sched (16-bit words, 4 reqs).
module tb_popcount_sched;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CW = 5;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][DW-1:0]  words;
  logic [NR*DW-1:0]       req_data;
  logic [NR-1:0]          req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IW-1:0]          rsp_id;
  logic [CW-1:0]          rsp_count;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt [4] = '{0, 1, 8, 8};

  assign req_data = words;

  always #5 clk = ~clk;

  popcount_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    words     = '0;

    // reset state
    mid();
    nxt(); mid();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_vld",   32'(rsp_valid), 0);
    check("rst_id",    32'(rsp_id),    0);
    check("rst_cnt",   32'(rsp_count), 0);

    // all-ones word, latency, RESP hold
    nxt(); resetn = 1'b1; req_valid = 4'b0001; words[0] = 16'hFFFF;
    mid(); check("ones_grant", 32'(req_ready), 32'h1);
    nxt(); req_valid = '0;
    mid(); check("ones_calc_vld", 32'(rsp_valid), 0);
    check("ones_calc_rdy", 32'(req_ready), 0);
    nxt(); req_valid = '1;
    mid(); check("ones_vld", 32'(rsp_valid), 1);
    check("ones_id",  32'(rsp_id),    0);
    check("ones_cnt", 32'(rsp_count), 16);
    check("ones_rdy", 32'(req_ready), 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); mid();
      check("hold_vld", 32'(rsp_valid), 1);
      check("hold_id",  32'(rsp_id),    0);
      check("hold_cnt", 32'(rsp_count), 16);
      check("hold_rdy", 32'(req_ready), 0);
    end
    nxt(); rsp_ready = 1'b1; req_valid = '0;
    mid(); check("hs_vld", 32'(rsp_valid), 1);
    nxt(); mid();
    check("hs_idle_vld", 32'(rsp_valid), 0);

    // round-robin with all requesters pending, back-to-back
    nxt(); resetn = 1'b0;
    nxt(); resetn = 1'b1; req_valid = '1;
    words[0] = 16'h0000; words[1] = 16'h0001; words[2] = 16'h00FF; words[3] = 16'hAAAA;
    for (int g = 0; g < 5; g++) begin
      mid(); check("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
      nxt(); if (g == 4) req_valid = '0;
      mid(); check("rr_calc_vld", 32'(rsp_valid), 0);
      check("rr_calc_rdy", 32'(req_ready), 0);
      nxt(); mid();
      check("rr_vld", 32'(rsp_valid), 1);
      check("rr_id",  32'(rsp_id),    32'(g % 4));
      check("rr_cnt", 32'(rsp_count), 32'(exp_cnt[g % 4]));
      check("rr_rdy", 32'(req_ready), 0);
      nxt();
    end
    mid(); check("rr_end_vld", 32'(rsp_valid), 0);
    check("rr_end_rdy", 32'(req_ready), 0);

    // reset while in CALC discards the grant
    nxt(); req_valid = 4'b0100;
    mid(); check("abort_grant", 32'(req_ready), 32'h4);
    nxt(); req_valid = '0; resetn = 1'b0;
    mid(); check("abort_rst_rdy", 32'(req_ready), 0);
    nxt(); resetn = 1'b1; req_valid = '1;
    mid(); check("abort_no_rsp", 32'(rsp_valid), 0);
    check("abort_first", 32'(req_ready), 32'h1);
    nxt(); req_valid = '0;
    mid(); check("abort_calc_vld", 32'(rsp_valid), 0);
    nxt(); mid();
    check("abort_vld", 32'(rsp_valid), 1);
    check("abort_id",  32'(rsp_id),    0);
    check("abort_cnt", 32'(rsp_count), 0);
    nxt(); mid();
    check("abort_idle", 32'(rsp_valid), 0);

    // wrap: after grant 2, 0101 serves 0 then 2
    nxt(); req_valid = 4'b0100;
    mid(); check("wrap_pre", 32'(req_ready), 32'h4);
    nxt(); req_valid = '0;
    nxt(); mid();
    check("wrap_pre_id",  32'(rsp_id),    2);
    check("wrap_pre_cnt", 32'(rsp_count), 8);
    nxt(); req_valid = 4'b0101;
    mid(); check("wrap_grant0", 32'(req_ready), 32'h1);
    nxt(); mid();
    nxt(); mid();
    check("wrap_id0", 32'(rsp_id), 0);
    nxt(); mid();
    check("wrap_grant2", 32'(req_ready), 32'h4);
    nxt(); req_valid = '0;
    nxt(); mid();
    check("wrap_id2", 32'(rsp_id), 2);

    // data change after acceptance; dropped request never served
    nxt(); words[1] = 16'h0F0F; req_valid = 4'b0010;
    mid(); check("cap_grant", 32'(req_ready), 32'h2);
    nxt(); words[1] = 16'h0000; req_valid = 4'b1000;
    mid(); check("cap_calc_rdy", 32'(req_ready), 0);
    nxt(); req_valid = '0;
    mid(); check("cap_vld", 32'(rsp_valid), 1);
    check("cap_id",  32'(rsp_id),    1);
    check("cap_cnt", 32'(rsp_count), 8);
    nxt(); mid();
    check("drop_rdy", 32'(req_ready), 0);
    check("drop_vld", 32'(rsp_valid), 0);
    nxt(); mid();
    check("drop_no_rsp", 32'(rsp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
